// File: rtl/led_blink_pkg.sv
// Shared types and constants for the multi-channel LED blinker.
package led_blink_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    ON    = 2'b01,
    BLINK = 2'b10,
    PWM   = 2'b11
  } mode_t;

  localparam logic [1:0] ADDR_PERIOD = 2'd0;
  localparam logic [1:0] ADDR_DUTY   = 2'd1;
  localparam logic [1:0] ADDR_MODE   = 2'd2;

  // Channel-select width; a single channel still needs a 1-bit select.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_blink_multi_if.sv
// Configuration write port and LED outputs of led_blink_multi.
// LED_BLINK_SYNC_EN adds the i_sync input.
interface led_blink_multi_if
  import led_blink_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  localparam int CH_W = ch_width(NUM_CH);

  logic              i_enable;
  logic              i_wr_en;
  logic [CH_W-1:0]   i_wr_ch;
  logic [1:0]        i_wr_addr;
  logic [CNT_W-1:0]  i_wr_data;
`ifdef LED_BLINK_SYNC_EN
  logic              i_sync;
`endif
  logic [NUM_CH-1:0] o_led;
  logic [NUM_CH-1:0] o_period_tick;

  modport master (
    output i_enable, i_wr_en, i_wr_ch, i_wr_addr, i_wr_data,
`ifdef LED_BLINK_SYNC_EN
    output i_sync,
`endif
    input  o_led, o_period_tick
  );

  modport slave (
    input  i_enable, i_wr_en, i_wr_ch, i_wr_addr, i_wr_data,
`ifdef LED_BLINK_SYNC_EN
    input  i_sync,
`endif
    output o_led, o_period_tick
  );

endinterface

// File: rtl/led_blink_channel.sv
// One LED channel: period counter, shadowed period/duty, mode, blink toggle
// and the registered LED/tick outputs.
module led_blink_channel
  import led_blink_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int RST_PERIOD = 12500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [CNT_W-1:0] wr_data,
  output logic             led,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] duty;
  logic [CNT_W-1:0] period_sh;
  logic [CNT_W-1:0] duty_sh;
  logic             pend;
  logic             tg;
  mode_t            mode;
  logic             wrap;
  logic             raw;

  // A zero period behaves as a one-cycle period: cnt stays 0, wraps each cycle.
  always_comb begin
    wrap = (period == '0) || (cnt == period - CNT_W'(1)) || sync;
    raw  = 1'b0;
    case (mode)
      OFF:     raw = 1'b0;
      ON:      raw = 1'b1;
      BLINK:   raw = tg;
      PWM:     raw = (cnt < duty);
      default: raw = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      period    <= CNT_W'(RST_PERIOD);
      period_sh <= CNT_W'(RST_PERIOD);
      duty      <= '0;
      duty_sh   <= '0;
      pend      <= 1'b0;
      mode      <= OFF;
      tg        <= 1'b0;
      led       <= 1'b0;
      tick      <= 1'b0;
    end else begin
      cnt  <= wrap ? '0 : cnt + CNT_W'(1);
      tick <= wrap;
      led  <= raw & enable;
      if (sync)
        tg <= 1'b0;
      else if (wrap)
        tg <= ~tg;
      if (wrap && pend) begin
        period <= period_sh;
        duty   <= duty_sh;
        pend   <= 1'b0;
      end
      // Placed after the wrap update so a same-cycle write keeps pend set.
      if (wr_en) begin
        case (wr_addr)
          ADDR_PERIOD: begin
            period_sh <= wr_data;
            pend      <= 1'b1;
          end
          ADDR_DUTY: begin
            duty_sh <= wr_data;
            pend    <= 1'b1;
          end
          ADDR_MODE: mode <= mode_t'(wr_data[1:0]);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/led_blink_multi.sv
// NUM_CH independent LED channels with glitch-free runtime reconfiguration.
// Optional LED_BLINK_SYNC_EN: i_sync forces a simultaneous wrap on all channels.
module led_blink_multi
  import led_blink_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int RST_PERIOD = 12500
) (
  input logic               i_clock,
  input logic               i_reset,
  led_blink_multi_if.slave  bus
);

  localparam int CH_W = ch_width(NUM_CH);

  logic              sync;
  logic [NUM_CH-1:0] led_vec;
  logic [NUM_CH-1:0] tick_vec;

`ifdef LED_BLINK_SYNC_EN
  assign sync = bus.i_sync;
`else
  assign sync = 1'b0;
`endif

  assign bus.o_led         = led_vec;
  assign bus.o_period_tick = tick_vec;

  // Out-of-range channel numbers match no instance and are dropped.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic wr_sel;
    assign wr_sel = bus.i_wr_en && (bus.i_wr_ch == CH_W'(g));

    led_blink_channel #(
      .CNT_W      (CNT_W),
      .RST_PERIOD (RST_PERIOD)
    ) u_ch (
      .clk     (i_clock),
      .rst     (i_reset),
      .enable  (bus.i_enable),
      .sync    (sync),
      .wr_en   (wr_sel),
      .wr_addr (bus.i_wr_addr),
      .wr_data (bus.i_wr_data),
      .led     (led_vec[g]),
      .tick    (tick_vec[g])
    );
  end

endmodule

// File: tb/tb_led_blink_multi.sv
// Directed self-checking bench for led_blink_multi (five channels, 12500 reset period).
module tb_led_blink_multi;
  import led_blink_pkg::*;

  localparam int NUM_CH     = 5;
  localparam int CNT_W      = 32;
  localparam int RST_PERIOD = 12500;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   w0       = 0;

  led_blink_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  led_blink_multi #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .RST_PERIOD (RST_PERIOD)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ph(input int p);
    return (cyc - w0) % p;
  endfunction

  task automatic wr(input logic [2:0] ch, input logic [1:0] addr, input logic [CNT_W-1:0] data);
    bus.i_wr_en   = 1'b1;
    bus.i_wr_ch   = ch;
    bus.i_wr_addr = addr;
    bus.i_wr_data = data;
    @(negedge clk);
    bus.i_wr_en   = 1'b0;
  endtask

  task automatic wait_tick(input int ch, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.o_period_tick[ch] !== 1'b1 && n < budget);
  endtask

  task automatic goto_phase(input int p, input int target);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ph(p) != target && n <= p);
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.o_led !== 5'b00000) begin
      failures++; $display("FAIL reset_led: got %b expected 00000", bus.o_led);
    end
    checks++;
    if (bus.o_period_tick !== 5'b00000) begin
      failures++; $display("FAIL reset_tick: got %b expected 00000", bus.o_period_tick);
    end
    wait_tick(0, 13000, n);
    checks++;
    if (n != 12500) begin
      failures++; $display("FAIL reset_first_tick: got %0d cycles expected 12500", n);
    end
    checks++;
    if (bus.o_period_tick !== 5'b11111) begin
      failures++; $display("FAIL reset_all_tick: got %b expected 11111", bus.o_period_tick);
    end
  endtask

  task automatic test_blink();
    int n, k;
    logic e;
    wr(3'd0, ADDR_PERIOD, 32'd4);
    wr(3'd0, ADDR_MODE, 32'(BLINK));
    wr(3'd1, ADDR_PERIOD, 32'd10);
    wr(3'd1, ADDR_DUTY, 32'd3);
    wr(3'd1, ADDR_MODE, 32'(PWM));
    // New period must wait for the running 12500-cycle period to finish.
    wait_tick(0, 13000, n);
    w0 = cyc;
    checks++;
    if (n != 12495) begin
      failures++; $display("FAIL blink_shadow_wait: got %0d cycles expected 12495", n);
    end
    checks++;
    if (bus.o_led[1:0] !== 2'b01) begin
      failures++; $display("FAIL blink_led_at_apply: got %b expected 01", bus.o_led[1:0]);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      k = cyc - w0;
      e = (((k - 1) / 4) % 2) == 1;
      checks++;
      if (bus.o_led[0] !== e) begin
        failures++; $display("FAIL blink_led0 k=%0d: got %b expected %b", k, bus.o_led[0], e);
      end
      e = (k % 4) == 0;
      checks++;
      if (bus.o_period_tick[0] !== e) begin
        failures++; $display("FAIL blink_tick0 k=%0d: got %b expected %b", k, bus.o_period_tick[0], e);
      end
    end
  endtask

  task automatic test_pwm();
    int k;
    logic e;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      k = cyc - w0;
      e = ((k - 1) % 10) < 3;
      checks++;
      if (bus.o_led[1] !== e) begin
        failures++; $display("FAIL pwm_led1 k=%0d: got %b expected %b", k, bus.o_led[1], e);
      end
      e = (k % 10) == 0;
      checks++;
      if (bus.o_period_tick[1] !== e) begin
        failures++; $display("FAIL pwm_tick1 k=%0d: got %b expected %b", k, bus.o_period_tick[1], e);
      end
    end
  endtask

  task automatic test_glitch();
    int pp;
    logic e;
    // Duty 3 -> 7 written while cnt=5: the rest of this period keeps duty 3.
    goto_phase(10, 5);
    wr(3'd1, ADDR_DUTY, 32'd7);
    for (int i = 0; i < 15; i++) begin
      pp = (ph(10) == 0) ? 10 : ph(10);
      e = (i < 5) ? ((pp - 1) < 3) : ((pp - 1) < 7);
      checks++;
      if (bus.o_led[1] !== e) begin
        failures++; $display("FAIL glitch_mid i=%0d: got %b expected %b", i, bus.o_led[1], e);
      end
      @(negedge clk);
    end
    // Duty 2 written on the wrap edge lands one full period later.
    goto_phase(10, 9);
    wr(3'd1, ADDR_DUTY, 32'd2);
    for (int i = 0; i < 21; i++) begin
      pp = (ph(10) == 0) ? 10 : ph(10);
      e = (i <= 10) ? ((pp - 1) < 7) : ((pp - 1) < 2);
      checks++;
      if (bus.o_led[1] !== e) begin
        failures++; $display("FAIL glitch_wrap i=%0d: got %b expected %b", i, bus.o_led[1], e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_pwm_limits();
    logic [CNT_W-1:0] dv [3];
    logic             ev [3];
    dv[0] = 32'd0;  ev[0] = 1'b0;
    dv[1] = 32'd10; ev[1] = 1'b1;
    dv[2] = 32'd15; ev[2] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      goto_phase(10, 2);
      wr(3'd1, ADDR_DUTY, dv[j]);
      goto_phase(10, 1);
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (bus.o_led[1] !== ev[j]) begin
          failures++; $display("FAIL pwm_limit d=%0d i=%0d: got %b expected %b", dv[j], i, bus.o_led[1], ev[j]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_enable();
    int k;
    logic e;
    bus.i_enable = 1'b0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      k = cyc - w0;
      checks++;
      if (bus.o_led !== 5'b00000) begin
        failures++; $display("FAIL enable_off_led i=%0d: got %b expected 00000", i, bus.o_led);
      end
      e = (k % 4) == 0;
      checks++;
      if (bus.o_period_tick[0] !== e) begin
        failures++; $display("FAIL enable_off_tick0 k=%0d: got %b expected %b", k, bus.o_period_tick[0], e);
      end
    end
    bus.i_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      k = cyc - w0;
      e = (((k - 1) / 4) % 2) == 1;
      checks++;
      if (bus.o_led[0] !== e) begin
        failures++; $display("FAIL enable_phase k=%0d: got %b expected %b", k, bus.o_led[0], e);
      end
    end
  endtask

  task automatic test_invalid();
    int k;
    logic e;
    wr(3'd5, ADDR_MODE, 32'(ON));
    wr(3'd7, ADDR_MODE, 32'(ON));
    wr(3'd2, 2'd3, 32'd1);
    wr(3'd0, 2'd3, 32'd3);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      k = cyc - w0;
      e = (((k - 1) / 4) % 2) == 1;
      checks++;
      if (bus.o_led[0] !== e) begin
        failures++; $display("FAIL invalid_led0 k=%0d: got %b expected %b", k, bus.o_led[0], e);
      end
      checks++;
      if (bus.o_led[1] !== 1'b1) begin
        failures++; $display("FAIL invalid_led1 k=%0d: got %b expected 1", k, bus.o_led[1]);
      end
      checks++;
      if (bus.o_led[4:2] !== 3'b000) begin
        failures++; $display("FAIL invalid_led_hi k=%0d: got %b expected 000", k, bus.o_led[4:2]);
      end
    end
  endtask

`ifdef LED_BLINK_SYNC_EN
  task automatic test_sync();
    logic e;
    wr(3'd1, ADDR_PERIOD, 32'd6);
    wr(3'd1, ADDR_MODE, 32'(BLINK));
    repeat (3) @(negedge clk);
    bus.i_sync = 1'b1;
    @(negedge clk);
    bus.i_sync = 1'b0;
    checks++;
    if (bus.o_period_tick !== 5'b11111) begin
      failures++; $display("FAIL sync_tick: got %b expected 11111", bus.o_period_tick);
    end
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      e = (((i - 1) / 4) % 2) == 1;
      checks++;
      if (bus.o_led[0] !== e) begin
        failures++; $display("FAIL sync_led0 i=%0d: got %b expected %b", i, bus.o_led[0], e);
      end
      e = (((i - 1) / 6) % 2) == 1;
      checks++;
      if (bus.o_led[1] !== e) begin
        failures++; $display("FAIL sync_led1 i=%0d: got %b expected %b", i, bus.o_led[1], e);
      end
      e = (i % 4) == 0;
      checks++;
      if (bus.o_period_tick[0] !== e) begin
        failures++; $display("FAIL sync_tick0 i=%0d: got %b expected %b", i, bus.o_period_tick[0], e);
      end
      e = (i % 6) == 0;
      checks++;
      if (bus.o_period_tick[1] !== e) begin
        failures++; $display("FAIL sync_tick1 i=%0d: got %b expected %b", i, bus.o_period_tick[1], e);
      end
    end
    bus.i_sync = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    bus.i_sync = 1'b0;
    rst = 1'b0;
    checks++;
    if (bus.o_period_tick !== 5'b00000) begin
      failures++; $display("FAIL sync_reset_tick: got %b expected 00000", bus.o_period_tick);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.o_led !== 5'b00000) begin
        failures++; $display("FAIL sync_reset_led i=%0d: got %b expected 00000", i, bus.o_led);
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    rst           = 1'b1;
    bus.i_enable  = 1'b1;
    bus.i_wr_en   = 1'b0;
    bus.i_wr_ch   = '0;
    bus.i_wr_addr = '0;
    bus.i_wr_data = '0;
`ifdef LED_BLINK_SYNC_EN
    bus.i_sync    = 1'b0;
`endif
    test_reset();
    test_blink();
    test_pwm();
    test_glitch();
    test_pwm_limits();
    test_enable();
    test_invalid();
`ifdef LED_BLINK_SYNC_EN
    test_sync();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
